imem_boot_loader: RTL and testbench

//   Writer side of the instruction-memory interface: receives a program as a byte stream,

---
 rtl/imem_boot_pkg.sv | 15 +
 rtl/imem_boot_loader_byte_packer.sv | 32 +++
 rtl/imem_boot_loader.sv | 126 ++++++++++++
 tb/tb_imem_boot_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared state encoding and framing constants for the instruction-memory boot loader.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is a
// combinational pulse on the cycle the fourth byte of a word is presented.
module byte_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    // Earlier bytes shift down so byte0 ends up in the low lane.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes packed words into
// instruction memory while the core is held in reset, then releases the core.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, core held, no bytes accepted
// HDR   | collecting the 2-byte little-endian word count
// LOAD  | collecting payload bytes, one memory write per 4 bytes
// DONE  | image written, core released one cycle after the last write
// ERR   | word count exceeded memory depth, core held
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    state_t      state, state_nxt;
    logic        accept;
    logic        start_ok;
    logic        hdr_cnt;
    logic        hdr_last;
    logic [7:0]  hdr_lo;
    logic [15:0] hdr_n;
    logic [15:0] words_left;
    logic        last_word;
    logic        word_valid;
    logic [31:0] word;

    assign rx_ready  = (state == HDR) || (state == LOAD);
    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign hdr_n     = {rx_data, hdr_lo};
    assign hdr_last  = (state == HDR) && accept && (hdr_cnt == 1'(HDR_BYTES - 1));
    // words_left is a down-counter; the final word is its terminal count.
    assign last_word = word_valid && (words_left == 16'd1);

    assign busy  = (state == HDR) || (state == LOAD);
    assign done  = (state == DONE);
    assign error = (state == ERR);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (accept && (state == LOAD)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is ignored while a session is in progress.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = HDR;
            HDR: begin
                if (hdr_last) begin
                    if (hdr_n > 16'(DEPTH))  state_nxt = ERR;
                    else if (hdr_n == 16'd0) state_nxt = DONE;
                    else                     state_nxt = LOAD;
                end
            end
            LOAD: if (last_word) state_nxt = DONE;
            DONE: if (start) state_nxt = HDR;
            ERR:  if (start) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Header capture, write port, counters and core reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt      <= 1'b0;
            hdr_lo       <= 8'd0;
            words_left   <= 16'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            core_rst     <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            imem_we  <= word_valid;
            // Released only from a settled DONE, so the release trails the last write.
            core_rst <= (state == DONE) && !start;
            if (start_ok) begin
                hdr_cnt      <= 1'b0;
                words_loaded <= 16'd0;
                imem_addr    <= BASE_ADDR;
            end
            if ((state == HDR) && accept) begin
                hdr_cnt <= hdr_cnt + 1'b1;
                if (hdr_last) words_left <= hdr_n;
                else          hdr_lo     <= rx_data;
            end
            if (word_valid) begin
                imem_wdata   <= word;
                imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
                words_left   <= words_left - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames
// checked against a queue of expected (address, word) writes.
module tb_imem_boot_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, imem_we, core_rst, busy, done, error;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    imem_boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write pulse must match the next expected write, with the core held.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", imem_addr, imem_wdata);
            end else begin
                chk("wr_addr", imem_addr, exp_addr_q.pop_front());
                chk("wr_data", imem_wdata, exp_data_q.pop_front());
                chk("core_rst_during_write", {31'd0, core_rst}, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = rx_ready;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte %h never accepted", b);
        end
    endtask

    // gap: 0 back-to-back, 1 one idle cycle after each byte, 2 random gaps plus a stray start.
    task automatic gap_after(input int gap, input int idx);
        if (gap == 1) idle(1);
        else if (gap == 2) begin
            if (idx == 5) pulse_start();
            idle($urandom_range(0, 2));
        end
    endtask

    // Runs one full session of n words; literal=1 uses the fixed two-word program.
    task automatic run_load(input int n, input int gap, input bit literal);
        logic [7:0]  b[$];
        logic [31:0] w;
        logic [15:0] nn;
        b.delete();
        if (literal) begin
            b = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'hC0, 8'hFF};
            exp_addr_q.push_back(32'h0);  exp_data_q.push_back(32'h00400093);
            exp_addr_q.push_back(32'h4);  exp_data_q.push_back(32'hFFC00113);
        end else begin
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                exp_addr_q.push_back(BASE + 32'(4 * k));
                exp_data_q.push_back(w);
                b.push_back(w[7:0]);   b.push_back(w[15:8]);
                b.push_back(w[23:16]); b.push_back(w[31:24]);
            end
        end
        nn = 16'(n);
        pulse_start();
        chk("start_core_rst", {31'd0, core_rst}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_words", {16'd0, words_loaded}, 32'd0);
        chk("start_addr", imem_addr, BASE);
        send_byte(nn[7:0]);  gap_after(gap, 0);
        send_byte(nn[15:8]); gap_after(gap, 0);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i]);
            if (i != b.size() - 1) gap_after(gap, i);
        end
        chk("last_done", {31'd0, done}, 32'd1);
        chk("last_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("last_core_rst", {31'd0, core_rst}, 32'd0);
        chk("last_we", {31'd0, imem_we}, 32'd1);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("release_core_rst", {31'd0, core_rst}, 32'd1);
        chk("release_we", {31'd0, imem_we}, 32'd0);
        chk("release_words", {16'd0, words_loaded}, 32'(n));
        @(negedge clk);
        rx_valid = 1'b0;
        chk("extra_byte_words", {16'd0, words_loaded}, 32'(n));
        chk("extra_byte_done", {31'd0, done}, 32'd1);
        chk("writes_all_seen", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"}, imem_addr, BASE);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic run_error(input logic [15:0] n);
        pulse_start();
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        chk("err_error", {31'd0, error}, 32'd1);
        chk("err_core_rst", {31'd0, core_rst}, 32'd0);
        chk("err_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("err_busy", {31'd0, busy}, 32'd0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("err_hold", {31'd0, error}, 32'd1);
        chk("err_core_rst_hold", {31'd0, core_rst}, 32'd0);
        chk("err_words", {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("por");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_core_rst", {31'd0, core_rst}, 32'd0);
            chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        end

        run_load(2, 0, 1'b1);
        run_load(2, 1, 1'b1);
        run_error(16'd65);

        // Empty image: straight to DONE, core released on the following cycle.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_core_rst_early", {31'd0, core_rst}, 32'd0);
        @(negedge clk);
        chk("zero_core_rst", {31'd0, core_rst}, 32'd1);
        chk("zero_words", {16'd0, words_loaded}, 32'd0);

        // Reset in the middle of the second word discards the partial word.
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'h00400093);
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst");
        chk("midrst_writes_seen", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        run_load(2, 0, 1'b1);

        for (int f = 0; f < 6; f++) run_load($urandom_range(1, 6), 2, 1'b0);
        run_load(DEPTH, 0, 1'b0);
        run_error(16'(DEPTH + 1));
        run_load(1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
